// File: rtl/si5340_i2c_target_model.sv
// I2C register target modelling the Si5340 programming port: 7-bit device address,
// 16-bit register pointer, byte storage, committed-write strobe and backdoor read port.
module si5340_i2c_target_model #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h74,
  parameter int unsigned PTR_WIDTH   = 16,
  parameter int unsigned REG_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_pad_i,
  input  logic                         sda_pad_i,
  output logic                         sda_pad_o,
  output logic                         sda_padoen_o,
  output logic                         wr_valid_o,
  output logic [PTR_WIDTH-1:0]         wr_addr_o,
  output logic [7:0]                   wr_data_o,
  output logic                         busy_o,
  input  logic [$clog2(REG_DEPTH)-1:0] lcl_addr_i,
  output logic [7:0]                   lcl_data_o
);
  localparam int unsigned IDX_W = $clog2(REG_DEPTH);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK, PTR_HI, PTR_LO, WR_DATA, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_q, sda_q;
  state_e                 state_q, next_q;
  logic [3:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             tx_q;
  logic                   ack_ph_q;
  logic [PTR_WIDTH-1:0]   ptr_q;
  logic [7:0]             ptr_hi_q;
  logic                   oen_q, wr_valid_q, busy_q;
  logic [PTR_WIDTH-1:0]   wr_addr_q;
  logic [7:0]             wr_data_q, lcl_data_q;
  logic [7:0]             mem_q [REG_DEPTH];

  logic                   scl_s, sda_s;
  logic                   start_det, stop_det, scl_rise, scl_fall;
  logic [7:0]             rx_byte, rd_byte;
  logic                   byte_done, mem_we;
  logic [IDX_W-1:0]       idx;
  logic [PTR_WIDTH-1:0]   ptr_inc;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign rx_byte   = {shift_q, sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
  assign idx       = ptr_q[IDX_W-1:0];
  assign rd_byte   = mem_q[idx];
  assign ptr_inc   = ptr_q + PTR_WIDTH'(1);
  assign mem_we    = !rst_i && !start_det && !stop_det && (state_q == WR_DATA) && byte_done;

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign lcl_data_o   = lcl_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_pad_i};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      next_q     <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ack_ph_q   <= 1'b0;
      ptr_q      <= '0;
      ptr_hi_q   <= '0;
      oen_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_det) begin
        state_q <= IDLE;
        oen_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state_q   <= DEV_ADDR;
        bit_cnt_q <= '0;
        oen_q     <= 1'b1;
      end else if (scl_rise) begin
        case (state_q)
          DEV_ADDR, PTR_HI, PTR_LO, WR_DATA: begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (byte_done) begin
              state_q   <= ACK;
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= '0;
              case (state_q)
                DEV_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    busy_q <= 1'b1;
                    next_q <= rx_byte[0] ? RD_DATA : PTR_HI;
                  end else begin
                    state_q <= IDLE;
                  end
                end
                PTR_HI: begin
                  ptr_hi_q <= rx_byte;
                  next_q   <= PTR_LO;
                end
                PTR_LO: begin
                  ptr_q  <= PTR_WIDTH'({ptr_hi_q, rx_byte});
                  next_q <= WR_DATA;
                end
                WR_DATA: begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ptr_q;
                  wr_data_q  <= rx_byte;
                  ptr_q      <= ptr_inc;
                  next_q     <= WR_DATA;
                end
                default: ;
              endcase
            end
          end
          RD_ACK: begin
            // ack_ph_q marks a master ACK seen; the next byte loads at the following fall
            if (!ack_ph_q) begin
              if (!sda_s) begin
                ptr_q    <= ptr_inc;
                ack_ph_q <= 1'b1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ACK: begin
            if (!ack_ph_q) begin
              oen_q    <= 1'b0;
              ack_ph_q <= 1'b1;
            end else if (next_q == RD_DATA) begin
              oen_q     <= rd_byte[7];
              tx_q      <= {rd_byte[6:0], 1'b0};
              bit_cnt_q <= 4'd1;
              state_q   <= RD_DATA;
            end else begin
              oen_q     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= next_q;
            end
          end
          RD_DATA: begin
            if (bit_cnt_q == 4'd8) begin
              oen_q    <= 1'b1;
              ack_ph_q <= 1'b0;
              state_q  <= RD_ACK;
            end else begin
              oen_q     <= tx_q[7];
              tx_q      <= {tx_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          RD_ACK: begin
            if (ack_ph_q) begin
              oen_q     <= rd_byte[7];
              tx_q      <= {rd_byte[6:0], 1'b0};
              bit_cnt_q <= 4'd1;
              state_q   <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately unreset; backdoor read sees the pre-write value in a write cycle
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx] <= rx_byte;
    lcl_data_q <= mem_q[lcl_addr_i];
  end

endmodule

// File: tb/tb_si5340_i2c_target_model.sv
// Bench for si5340_i2c_target_model: bit-banged I2C master, behavioural register-file model,
// directed scenarios followed by randomized write/read/backdoor traffic.
module tb_si5340_i2c_target_model;
  localparam int Q = 5;
  localparam logic [6:0] DEV = 7'h74;

  logic        clk = 1'b0;
  logic        rst_i, scl_m, sda_m;
  logic [7:0]  lcl_addr;
  logic        sda_pad_o, sda_padoen_o, wr_valid_o, busy_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o, lcl_data_o;
  logic        sda_bus;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  si5340_i2c_target_model #(
    .SLAVE_ADDR(7'h74), .PTR_WIDTH(16), .REG_DEPTH(256), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .lcl_addr_i(lcl_addr), .lcl_data_o(lcl_data_o)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] wr_log[$];
  int          busy_cnt = 0, drove_cnt = 0, illegal_cnt = 0;
  logic        oen_prev = 1'b1;

  always @(negedge clk) begin
    if (wr_valid_o === 1'b1) wr_log.push_back({wr_addr_o, wr_data_o});
    if (busy_o === 1'b1) busy_cnt++;
    if (sda_padoen_o === 1'b0) drove_cnt++;
    if (rst_i === 1'b0 && sda_padoen_o !== oen_prev && scl_m === 1'b1) illegal_cnt++;
    oen_prev = sda_padoen_o;
  end

  logic [7:0]  mmem [256];
  bit          known [256];
  logic [15:0] mptr;
  logic [23:0] exp_q[$];
  int          wr_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_q.push_back({mptr, d});
    mmem[mptr[7:0]]  = d;
    known[mptr[7:0]] = 1'b1;
    mptr = mptr + 16'd1;
  endtask

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b1; hq();
    hq();
  endtask

  task automatic clk_bit(input logic b, output logic s, output logic oen);
    sda_m = b; hq();
    scl_m = 1'b1; hq();
    s = sda_bus; oen = sda_padoen_o; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    logic s, o;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s, o);
    clk_bit(1'b1, nack, o);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oen9);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s, o);
      d[i] = s;
    end
    clk_bit(nack, s, oen9);
  endtask

  task automatic xfer_write(input logic [6:0] dev, input logic [15:0] p, input logic [7:0] data[$],
                            output int nacks, output logic busy_pre, output logic busy_post);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte({dev, 1'b0}, a); nacks += int'(a);
    write_byte(p[15:8], a);     nacks += int'(a);
    write_byte(p[7:0], a);      nacks += int'(a);
    foreach (data[i]) begin
      write_byte(data[i], a); nacks += int'(a);
    end
    busy_pre = busy_o;
    i2c_stop();
    busy_post = busy_o;
    if (dev == DEV) begin
      mptr = p;
      foreach (data[i]) model_write(data[i]);
    end
  endtask

  task automatic read_xfer(input bit use_ptr, input logic [15:0] p, input int n);
    logic a, oen9;
    logic [7:0] d;
    int nacks;
    nacks = 0;
    i2c_start();
    if (use_ptr) begin
      write_byte({DEV, 1'b0}, a); nacks += int'(a);
      write_byte(p[15:8], a);     nacks += int'(a);
      write_byte(p[7:0], a);      nacks += int'(a);
      i2c_start();
      mptr = p;
    end
    write_byte({DEV, 1'b1}, a); nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d, oen9);
      if (known[mptr[7:0]]) chk("rd_data", d, mmem[mptr[7:0]]);
      chk("rd_ack_release", oen9, 1'b1);
      if (i != n - 1) mptr = mptr + 16'd1;
    end
    i2c_stop();
    chk("rd_stop_release", sda_padoen_o, 1'b1);
    chk("rd_nacks", nacks, 0);
  endtask

  task automatic chk_writes();
    int got;
    got = wr_log.size() - wr_rd;
    chk("wr_count", got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++) chk("wr_event", wr_log[wr_rd + i], exp_q[i]);
    wr_rd = wr_log.size();
    exp_q.delete();
  endtask

  task automatic lcl_chk(input logic [7:0] i, input logic [7:0] e);
    lcl_addr = i;
    @(negedge clk); @(negedge clk);
    chk("lcl_data", lcl_data_o, e);
  endtask

  initial begin
    logic [7:0] dq[$];
    logic       bp, bq, a, s, o, oen9;
    logic [7:0] d, hi;
    int         nacks, b0, dr0, op, n, off;

    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    mptr = '0;
    scl_m = 1'b1; sda_m = 1'b1; lcl_addr = '0; rst_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_oen", sda_padoen_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wr_valid", wr_valid_o, 1'b0);
    chk("rst_wr_addr", wr_addr_o, 16'h0000);
    chk("rst_wr_data", wr_data_o, 8'h00);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);

    // single write
    dq = {8'hA5};
    xfer_write(DEV, 16'h0012, dq, nacks, bp, bq);
    chk("sw_acks", nacks, 0);
    chk("sw_busy_before_stop", bp, 1'b1);
    chk("sw_busy_after_stop", bq, 1'b0);
    chk_writes();
    lcl_chk(8'h12, 8'hA5);

    // burst across pointer wrap
    dq = {8'h11, 8'h22};
    xfer_write(DEV, 16'hFFFF, dq, nacks, bp, bq);
    chk("wrap_acks", nacks, 0);
    chk_writes();
    lcl_chk(8'hFF, 8'h11);
    lcl_chk(8'h00, 8'h22);

    // random read with repeated start
    dq = {8'hA5, 8'h5A};
    xfer_write(DEV, 16'h0012, dq, nacks, bp, bq);
    chk_writes();
    read_xfer(1'b1, 16'h0012, 2);
    chk_writes();

    // address mismatch
    b0 = busy_cnt; dr0 = drove_cnt;
    dq = {8'h77};
    xfer_write(7'h75, 16'h0012, dq, nacks, bp, bq);
    chk("mm_nacks", nacks, 4);
    chk("mm_busy", busy_cnt - b0, 0);
    chk("mm_sda_driven", drove_cnt - dr0, 0);
    chk_writes();
    lcl_chk(8'h12, 8'hA5);

    // aborted data byte
    dq = {8'h3C};
    xfer_write(DEV, 16'h0020, dq, nacks, bp, bq);
    chk_writes();
    i2c_start();
    write_byte({DEV, 1'b0}, a);
    write_byte(8'h00, a);
    write_byte(8'h20, a);
    clk_bit(1'b1, s, o); clk_bit(1'b0, s, o); clk_bit(1'b1, s, o); clk_bit(1'b0, s, o);
    i2c_stop();
    chk("abort_busy", busy_o, 1'b0);
    chk_writes();
    lcl_chk(8'h20, 8'h3C);

    // reset while the target drives a 0 data bit (reg 0x13 = 0x5A, MSB 0)
    i2c_start();
    write_byte({DEV, 1'b0}, a);
    write_byte(8'h00, a);
    write_byte(8'h13, a);
    i2c_start();
    write_byte({DEV, 1'b1}, a);
    chk("rr_driving0", sda_padoen_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rr_oen_released", sda_padoen_o, 1'b1);
    chk("rr_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    mptr = 16'h0000;
    repeat (4) @(negedge clk);
    i2c_stop();
    read_xfer(1'b0, 16'h0000, 1);
    dq = {8'h99};
    xfer_write(DEV, 16'h0040, dq, nacks, bp, bq);
    chk("rr_write_acks", nacks, 0);
    chk_writes();
    lcl_chk(8'h40, 8'h99);

    // randomized traffic around a preloaded window
    hi = 8'($urandom_range(0, 255));
    dq.delete();
    for (int i = 0; i < 16; i++) dq.push_back(8'($urandom_range(0, 255)));
    xfer_write(DEV, {hi, 8'h80}, dq, nacks, bp, bq);
    chk("pre_acks", nacks, 0);
    chk_writes();
    for (int it = 0; it < 20; it++) begin
      op  = $urandom_range(0, 3);
      hi  = 8'($urandom_range(0, 255));
      off = $urandom_range(0, 12);
      case (op)
        0: begin
          n = $urandom_range(1, 4);
          dq.delete();
          for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
          xfer_write(DEV, {hi, 8'(8'h80 + off)}, dq, nacks, bp, bq);
          chk("rnd_wr_acks", nacks, 0);
          chk_writes();
        end
        1: read_xfer(1'b1, {hi, 8'(8'h80 + off)}, $urandom_range(1, 3));
        2: read_xfer(1'b0, 16'h0000, 1);
        default: begin
          d = 8'(8'h80 + $urandom_range(0, 15));
          if (known[d]) lcl_chk(d, mmem[d]);
        end
      endcase
    end
    chk_writes();
    chk("sda_change_while_scl_high", illegal_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
